ex_stage_muldiv: RTL and testbench
==================================

Name: ex_stage_muldiv

Overview:
- Execute stage of the 5-stage pipeline; sits directly downstream of the forwarding unit and consumes its forward1_EX/forward2_EX selects.
- Selects forwarded operands, runs single-cycle ALU ops and iterative unsigned MUL/DIVU/REMU, and owns the EX/MEM pipeline register.
- Raises stall_EX to freeze IF/ID/EX while a multi-cycle op is in flight.

Parameters:
- XLEN, 32, datapath width; multi-cycle op iteration count equals XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_EX  in  1  an instruction occupies EX.
- op_EX  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (low XLEN), 11 DIVU, 12 REMU; 13-15 behave as ADD.
- rs1_data_EX, rs2_data_EX  in  XLEN  register-file read data.
- imm_EX  in  XLEN  sign-extended immediate.
- ALUSrc_EX  in  1  1 = operand B is imm_EX, applied after forwarding.
- forward1_EX, forward2_EX  in  2  00 reg data, 10 EX/MEM result, 01 wb_data_WB, 11 treated as 00.
- wb_data_WB  in  XLEN  write-back value.
- reg_write_address_EX  in  5  destination register.
- RegWrite_EX  in  1  write enable.
- flush_EX  in  1  kill the instruction in EX.
- stall_EX  out  1  freeze upstream stages; combinational.
- valid_MEM  out  1  EX/MEM valid.
- alu_result_MEM  out  XLEN  EX/MEM result; also the internal 10 forward source.
- reg_write_address_MEM  out  5  EX/MEM destination.
- RegWrite_MEM  out  1  EX/MEM write enable; forced 0 when valid_MEM=0.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; counter and internal operand/accumulator registers clear.
  - valid_MEM=0, alu_result_MEM=0, reg_write_address_MEM=0, RegWrite_MEM=0, stall_EX=0.
  - Reset during BUSY aborts the op with no result emitted.
- Operands:
  - A = fwd(forward1_EX).
  - B = ALUSrc_EX ? imm_EX : fwd(forward2_EX).
  - Forwarding uses alu_result_MEM before the clock edge.
- Single-cycle ops (op 0-9), valid_EX=1, FSM IDLE:
  - Result registered into EX/MEM at the next edge; latency 1; stall_EX=0.
  - Shift amount is B[4:0].
  - SLT is signed; SLTU is unsigned; results are 0/1 zero-extended.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, valid_EX=1, op 10-12, flush_EX=0:
    - stall_EX=1; capture A, B and op at the edge.
    - Counter = 0; next state BUSY.
  - BUSY:
    - stall_EX=1; one iteration per cycle.
    - MUL is shift-add; DIVU/REMU use restoring division.
    - After XLEN iterations (counter = XLEN-1) go to DONE.
  - DONE:
    - stall_EX=0; EX/MEM loads the result, write address and RegWrite at the edge; next state IDLE.
    - The same frozen instruction is still in EX and must not re-issue.
  - Issue cycle to result in EX/MEM: XLEN+2 edges; stall_EX high for XLEN+1 cycles.
- While stall_EX=1, EX/MEM loads a bubble each edge so older instructions drain through MEM/WB.
- Divide by zero still takes full latency: DIVU returns all ones; REMU returns the dividend.
- MUL returns the low XLEN bits of the unsigned product; it equals the signed low half.
- flush_EX=1:
  - EX/MEM loads a bubble at the edge.
  - In BUSY or DONE, the FSM returns to IDLE with no result.
  - flush_EX takes priority over issue and completion.
- valid_EX=0 in IDLE: EX/MEM loads a bubble.
- A bubble sets valid_MEM=0 and RegWrite_MEM=0. alu_result_MEM and reg_write_address_MEM are don't-care; the implementation holds them.
- Back-to-back: a muldiv following a muldiv issues in the cycle after DONE. A single-cycle op following DONE proceeds normally.

Test Plan:
- Reset: rst low mid-BUSY (counter 10) -> all outputs 0 immediately; FSM IDLE; no result after rst returns high.
- ADD with forward1=10 (EX/MEM=0x5), forward2=01 (wb=0x7), ALUSrc=0 -> next edge alu_result_MEM=0xC, valid_MEM=1.
- SRA A=0x80000000, imm=4, ALUSrc=1 -> 0xF8000000; SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
- MUL 0xFFFFFFFF*3 -> stall_EX high 33 cycles, then 0xFFFFFFFD in EX/MEM 34 edges after issue; 33 bubbles on valid_MEM.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
- flush_EX at BUSY counter 5 -> stall_EX drops next cycle, bubble in EX/MEM; subsequent ADD completes in 1 cycle.

Source files
------------

// File: rtl/ex_stage_muldiv.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative unsigned MUL/DIVU/REMU,
// and the EX/MEM pipeline register. stall_EX freezes upstream while a multi-cycle op runs.
module ex_stage_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_EX,
    input  logic [3:0]      op_EX,
    input  logic [XLEN-1:0] rs1_data_EX,
    input  logic [XLEN-1:0] rs2_data_EX,
    input  logic [XLEN-1:0] imm_EX,
    input  logic            ALUSrc_EX,
    input  logic [1:0]      forward1_EX,
    input  logic [1:0]      forward2_EX,
    input  logic [XLEN-1:0] wb_data_WB,
    input  logic [4:0]      reg_write_address_EX,
    input  logic            RegWrite_EX,
    input  logic            flush_EX,
    output logic            stall_EX,
    output logic            valid_MEM,
    output logic [XLEN-1:0] alu_result_MEM,
    output logic [4:0]      reg_write_address_MEM,
    output logic            RegWrite_MEM
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [3:0]      op_q, op_d;

    logic            valid_mem_q, valid_mem_d;
    logic            rw_mem_q, rw_mem_d;
    logic [XLEN-1:0] res_mem_q, res_mem_d;
    logic [4:0]      rd_mem_q, rd_mem_d;

    logic [XLEN-1:0] opa, opb, fwd2, alu_res, md_res;
    logic [4:0]      shamt;
    logic            is_md, issue;
    logic [XLEN:0]   trial;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;

    // Forwarding muxes; 11 falls back to register data.
    always_comb begin
        case (forward1_EX)
            2'b10:   opa = res_mem_q;
            2'b01:   opa = wb_data_WB;
            default: opa = rs1_data_EX;
        endcase
        case (forward2_EX)
            2'b10:   fwd2 = res_mem_q;
            2'b01:   fwd2 = wb_data_WB;
            default: fwd2 = rs2_data_EX;
        endcase
        opb   = ALUSrc_EX ? imm_EX : fwd2;
        shamt = opb[4:0];
    end

    always_comb begin
        alu_res = opa + opb;
        case (op_EX)
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_SLL:  alu_res = opa << shamt;
            OP_SRL:  alu_res = opa >> shamt;
            OP_SRA:  alu_res = $signed(opa) >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
            default: alu_res = opa + opb;
        endcase
    end

    assign is_md    = (op_EX == OP_MUL) || (op_EX == OP_DIVU) || (op_EX == OP_REMU);
    assign issue    = rst && (state_q == IDLE) && valid_EX && is_md && !flush_EX;
    assign stall_EX = issue || (state_q == BUSY);

    // Restoring division: a_q shifts dividend out / quotient in, acc_q is the partial remainder.
    assign trial    = {acc_q, a_q[XLEN-1]};
    assign div_ge   = trial >= {1'b0, b_q};
    assign div_diff = trial[XLEN-1:0] - b_q;
    assign md_res   = (op_q == OP_DIVU) ? a_q : acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    a_d     = opa;
                    b_d     = opb;
                    acc_d   = '0;
                    op_d    = op_EX;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (op_q == OP_MUL) begin
                    acc_d = acc_q + (b_q[0] ? a_q : '0);
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = div_ge ? div_diff : trial[XLEN-1:0];
                    a_d   = {a_q[XLEN-2:0], div_ge};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_EX) state_d = IDLE;
    end

    // EX/MEM: bubbles hold data/address and only clear the valid/write-enable bits.
    always_comb begin
        valid_mem_d = 1'b0;
        rw_mem_d    = 1'b0;
        res_mem_d   = res_mem_q;
        rd_mem_d    = rd_mem_q;
        if (!flush_EX) begin
            if (state_q == DONE) begin
                valid_mem_d = 1'b1;
                res_mem_d   = md_res;
                rd_mem_d    = reg_write_address_EX;
                rw_mem_d    = RegWrite_EX;
            end else if (state_q == IDLE && valid_EX && !is_md) begin
                valid_mem_d = 1'b1;
                res_mem_d   = alu_res;
                rd_mem_d    = reg_write_address_EX;
                rw_mem_d    = RegWrite_EX;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            op_q        <= '0;
            valid_mem_q <= 1'b0;
            rw_mem_q    <= 1'b0;
            res_mem_q   <= '0;
            rd_mem_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            valid_mem_q <= valid_mem_d;
            rw_mem_q    <= rw_mem_d;
            res_mem_q   <= res_mem_d;
            rd_mem_q    <= rd_mem_d;
        end
    end

    assign valid_MEM             = valid_mem_q;
    assign RegWrite_MEM          = rw_mem_q;
    assign alu_result_MEM        = res_mem_q;
    assign reg_write_address_MEM = rd_mem_q;

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Self-checking bench for ex_stage_muldiv: directed cases plus randomized ALU and
// mul/div traffic checked against an arithmetic reference model.
module tb_ex_stage_muldiv;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            valid_EX;
    logic [3:0]      op_EX;
    logic [XLEN-1:0] rs1_data_EX, rs2_data_EX, imm_EX, wb_data_WB;
    logic            ALUSrc_EX;
    logic [1:0]      forward1_EX, forward2_EX;
    logic [4:0]      reg_write_address_EX;
    logic            RegWrite_EX, flush_EX;
    logic            stall_EX, valid_MEM, RegWrite_MEM;
    logic [XLEN-1:0] alu_result_MEM;
    logic [4:0]      reg_write_address_MEM;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [XLEN-1:0] exp_res;

    ex_stage_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .valid_EX(valid_EX), .op_EX(op_EX),
        .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX), .imm_EX(imm_EX),
        .ALUSrc_EX(ALUSrc_EX), .forward1_EX(forward1_EX), .forward2_EX(forward2_EX),
        .wb_data_WB(wb_data_WB), .reg_write_address_EX(reg_write_address_EX),
        .RegWrite_EX(RegWrite_EX), .flush_EX(flush_EX), .stall_EX(stall_EX),
        .valid_MEM(valid_MEM), .alu_result_MEM(alu_result_MEM),
        .reg_write_address_MEM(reg_write_address_MEM), .RegWrite_MEM(RegWrite_MEM)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a << b[4:0];
            6:  return a >> b[4:0];
            7:  return $signed(a) >>> b[4:0];
            8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9:  return (a < b) ? 32'd1 : 32'd0;
            10: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            12: return (b == 0) ? a : a % b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                           input logic [31:0] exmem, input logic [31:0] wb);
        if (sel == 2'b10) return exmem;
        if (sel == 2'b01) return wb;
        return rf;
    endfunction

    task automatic drive_idle();
        valid_EX = 1'b0; op_EX = 4'd0; rs1_data_EX = '0; rs2_data_EX = '0; imm_EX = '0;
        ALUSrc_EX = 1'b0; forward1_EX = 2'b00; forward2_EX = 2'b00; wb_data_WB = '0;
        reg_write_address_EX = '0; RegWrite_EX = 1'b0; flush_EX = 1'b0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        valid_EX = 1'b1; op_EX = op; rs1_data_EX = a; rs2_data_EX = b; ALUSrc_EX = 1'b0;
        forward1_EX = 2'b00; forward2_EX = 2'b00; reg_write_address_EX = rd;
        RegWrite_EX = 1'b1; flush_EX = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        #12;
        total_cnt++;
        if (stall_EX !== 1'b0 || valid_MEM !== 1'b0 || alu_result_MEM !== '0 ||
            reg_write_address_MEM !== '0 || RegWrite_MEM !== 1'b0)
            $display("FAIL reset_state: got stall=%b v=%b res=%h rd=%h rw=%b, expected all 0",
                     stall_EX, valid_MEM, alu_result_MEM, reg_write_address_MEM, RegWrite_MEM);
        else pass_cnt++;
        exp_res = '0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        drive_op(4'd0, 32'h5, 32'h0, 5'd3);
        @(posedge clk); #1;
        total_cnt++;
        if (valid_MEM !== 1'b1 || alu_result_MEM !== 32'h5)
            $display("FAIL fwd_seed: got v=%b res=%h, expected v=1 res=5", valid_MEM, alu_result_MEM);
        else pass_cnt++;
        drive_op(4'd0, 32'hDEAD_0000, 32'h0BAD_0000, 5'd4);
        forward1_EX = 2'b10; forward2_EX = 2'b01; wb_data_WB = 32'h7;
        @(posedge clk); #1;
        total_cnt++;
        if (valid_MEM !== 1'b1 || alu_result_MEM !== 32'hC || reg_write_address_MEM !== 5'd4)
            $display("FAIL fwd_add: got v=%b res=%h rd=%0d, expected v=1 res=c rd=4",
                     valid_MEM, alu_result_MEM, reg_write_address_MEM);
        else pass_cnt++;
        exp_res = 32'hC;
        drive_idle();
    endtask

    task automatic test_directed_alu();
        logic [3:0]  ops [3]  = '{4'd7, 4'd8, 4'd9};
        logic [31:0] as  [3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3]  = '{32'h0, 32'h1, 32'h1};
        logic [31:0] ims [3]  = '{32'h4, 32'h0, 32'h0};
        logic        srcs[3]  = '{1'b1, 1'b0, 1'b0};
        logic [31:0] exps[3]  = '{32'hF800_0000, 32'h1, 32'h0};
        for (int i = 0; i < 3; i++) begin
            drive_op(ops[i], as[i], bs[i], 5'(i + 8));
            imm_EX = ims[i]; ALUSrc_EX = srcs[i];
            @(posedge clk); #1;
            total_cnt++;
            if (valid_MEM !== 1'b1 || alu_result_MEM !== exps[i])
                $display("FAIL directed_op%0d: got v=%b res=%h, expected v=1 res=%h",
                         ops[i], valid_MEM, alu_result_MEM, exps[i]);
            else pass_cnt++;
            exp_res = exps[i];
        end
        drive_idle();
    endtask

    task automatic test_random_alu();
        int op, r;
        logic v, rw, src;
        logic [1:0] f1, f2;
        logic [31:0] rs1, rs2, imm, wb, a, b, e;
        logic [4:0] rd;
        for (int i = 0; i < 60; i++) begin
            r   = int'($urandom_range(0, 12));
            op  = (r < 10) ? r : r + 3;
            v   = ($urandom_range(0, 3) != 0);
            f1  = 2'($urandom); f2 = 2'($urandom);
            rs1 = $urandom; rs2 = $urandom; imm = $urandom; wb = $urandom;
            if ($urandom_range(0, 3) == 0) rs2 = 32'($urandom_range(0, 40));
            src = 1'($urandom); rw = 1'($urandom); rd = 5'($urandom);
            a = ref_fwd(f1, rs1, exp_res, wb);
            b = src ? imm : ref_fwd(f2, rs2, exp_res, wb);
            e = ref_alu(op, a, b);
            valid_EX = v; op_EX = 4'(op); rs1_data_EX = rs1; rs2_data_EX = rs2; imm_EX = imm;
            wb_data_WB = wb; ALUSrc_EX = src; forward1_EX = f1; forward2_EX = f2;
            reg_write_address_EX = rd; RegWrite_EX = rw; flush_EX = 1'b0;
            #1;
            total_cnt++;
            if (stall_EX !== 1'b0) $display("FAIL rand_stall: got %b, expected 0", stall_EX);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (valid_MEM !== v || RegWrite_MEM !== (v & rw))
                $display("FAIL rand_valid_%0d: got v=%b rw=%b, expected v=%b rw=%b",
                         i, valid_MEM, RegWrite_MEM, v, v & rw);
            else pass_cnt++;
            if (v) begin
                total_cnt++;
                if (alu_result_MEM !== e || reg_write_address_MEM !== rd)
                    $display("FAIL rand_res_%0d op%0d: got res=%h rd=%0d, expected res=%h rd=%0d",
                             i, op, alu_result_MEM, reg_write_address_MEM, e, rd);
                else pass_cnt++;
                exp_res = e;
            end
        end
        drive_idle();
    endtask

    task automatic test_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] e);
        int stalls = 0, bubbles = 0;
        logic [4:0] rd = 5'($urandom_range(1, 31));
        drive_op(op, a, b, rd);
        #1;
        total_cnt++;
        if (stall_EX !== 1'b1) $display("FAIL md_issue_stall op%0d: got %b, expected 1", op, stall_EX);
        else pass_cnt++;
        while (stall_EX === 1'b1 && stalls < 100) begin
            @(posedge clk); #1;
            stalls++;
            if (valid_MEM === 1'b0 && RegWrite_MEM === 1'b0) bubbles++;
        end
        total_cnt++;
        if (stalls != XLEN + 1 || bubbles != XLEN + 1)
            $display("FAIL md_stall_len op%0d: got stalls=%0d bubbles=%0d, expected %0d each",
                     op, stalls, bubbles, XLEN + 1);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (valid_MEM !== 1'b1 || alu_result_MEM !== e || reg_write_address_MEM !== rd ||
            RegWrite_MEM !== 1'b1)
            $display("FAIL md_result op%0d %h,%h: got v=%b res=%h rd=%0d rw=%b, expected v=1 res=%h rd=%0d rw=1",
                     op, a, b, valid_MEM, alu_result_MEM, reg_write_address_MEM, RegWrite_MEM, e, rd);
        else pass_cnt++;
        exp_res = e;
        valid_EX = 1'b0;
    endtask

    task automatic test_muldiv_directed();
        test_muldiv(4'd10, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        test_muldiv(4'd11, 32'd100, 32'd7, 32'd14);
        test_muldiv(4'd12, 32'd100, 32'd7, 32'd2);
        test_muldiv(4'd11, 32'hCAFE_F00D, 32'd0, 32'hFFFF_FFFF);
        test_muldiv(4'd12, 32'h1234, 32'd0, 32'h1234);
        @(posedge clk); #1;
    endtask

    task automatic test_random_muldiv();
        logic [31:0] a, b;
        int op;
        for (int i = 0; i < 9; i++) begin
            op = 10 + (i % 3);
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            test_muldiv(4'(op), a, b, ref_alu(op, a, b));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        test_muldiv(4'd10, 32'h1234_5678, 32'h9ABC_DEF1, ref_alu(10, 32'h1234_5678, 32'h9ABC_DEF1));
        test_muldiv(4'd11, 32'hFFFF_0000, 32'h0000_0123, ref_alu(11, 32'hFFFF_0000, 32'h0000_0123));
        e = ref_alu(1, 32'd50, 32'd8);
        drive_op(4'd1, 32'd50, 32'd8, 5'd9);
        @(posedge clk); #1;
        total_cnt++;
        if (valid_MEM !== 1'b1 || alu_result_MEM !== e)
            $display("FAIL b2b_single: got v=%b res=%h, expected v=1 res=%h", valid_MEM, alu_result_MEM, e);
        else pass_cnt++;
        exp_res = e;
        drive_idle();
    endtask

    task automatic test_flush();
        int seen = 0;
        drive_op(4'd10, 32'd1000, 32'd1000, 5'd5);
        repeat (6) begin @(posedge clk); #1; end
        flush_EX = 1'b1;
        @(posedge clk); #1;
        flush_EX = 1'b0; valid_EX = 1'b0;
        #1;
        total_cnt++;
        if (stall_EX !== 1'b0 || valid_MEM !== 1'b0)
            $display("FAIL flush_busy: got stall=%b v=%b, expected 0 0", stall_EX, valid_MEM);
        else pass_cnt++;
        drive_op(4'd0, 32'd21, 32'd21, 5'd6);
        #1;
        total_cnt++;
        if (stall_EX !== 1'b0) $display("FAIL flush_add_stall: got %b, expected 0", stall_EX);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (valid_MEM !== 1'b1 || alu_result_MEM !== 32'd42)
            $display("FAIL flush_add: got v=%b res=%h, expected v=1 res=2a", valid_MEM, alu_result_MEM);
        else pass_cnt++;
        exp_res = 32'd42;
        drive_idle();
        repeat (40) begin @(posedge clk); #1; if (valid_MEM !== 1'b0) seen++; end
        total_cnt++;
        if (seen != 0) $display("FAIL flush_no_result: got %0d valid cycles, expected 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_reset_busy();
        int seen = 0;
        drive_op(4'd10, 32'hFFFF_FFFF, 32'd3, 5'd7);
        repeat (11) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        total_cnt++;
        if (stall_EX !== 1'b0 || valid_MEM !== 1'b0 || alu_result_MEM !== '0 ||
            reg_write_address_MEM !== '0 || RegWrite_MEM !== 1'b0)
            $display("FAIL reset_busy: got stall=%b v=%b res=%h rd=%h rw=%b, expected all 0",
                     stall_EX, valid_MEM, alu_result_MEM, reg_write_address_MEM, RegWrite_MEM);
        else pass_cnt++;
        exp_res = '0;
        drive_idle();
        @(negedge clk); rst = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (valid_MEM !== 1'b0 || stall_EX !== 1'b0) seen++; end
        total_cnt++;
        if (seen != 0) $display("FAIL reset_no_result: got %0d active cycles, expected 0", seen);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_directed_alu();
        test_random_alu();
        test_muldiv_directed();
        test_random_muldiv();
        test_back_to_back();
        test_flush();
        test_reset_busy();
        test_random_alu();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
